// File: rtl/divclk_monitor_if.sv
// divclk_monitor_if: div_in under test plus the monitor's status outputs.
// The monitor takes the slave side; whoever drives div_in takes master.
interface divclk_monitor_if;
  logic       div_in;
  logic       rise_pulse;
  logic       fall_pulse;
  logic [7:0] half_period;
  logic       period_valid;
  logic       locked;
  logic       err_pulse;
  logic       timeout;

  modport master (
    output div_in,
    input  rise_pulse, fall_pulse, half_period,
    input  period_valid, locked, err_pulse, timeout
  );

  modport slave (
    input  div_in,
    output rise_pulse, fall_pulse, half_period,
    output period_valid, locked, err_pulse, timeout
  );
endinterface

// File: rtl/divclk_monitor.sv
// divclk_monitor: measures div_in half-periods and tracks frequency lock.
// Define DIVMON_SYNC_EN to add a 2-flop synchronizer ahead of edge detect.
module divclk_monitor #(
  parameter int EXP_HALF = 8,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  divclk_monitor_if.slave mon
);
  localparam int TMO = 2 * EXP_HALF + TOL;
  localparam int LO  = (EXP_HALF > TOL) ? EXP_HALF - TOL : 0;
  localparam int HI  = EXP_HALF + TOL;

  localparam logic [9:0] LO_V   = 10'(LO);
  localparam logic [9:0] HI_V   = 10'(HI);
  localparam logic [9:0] TMO_V  = 10'(TMO);
  localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED,
    LOST
  } state_e;

  state_e     state_q, state_d;
  logic       prev_q, prev_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] good_cnt_q, good_cnt_d;
  logic [7:0] half_q, half_d;
  logic       rise_q, rise_d;
  logic       fall_q, fall_d;
  logic       pv_q, pv_d;
  logic       err_q, err_d;

  logic       sample;
  logic       edge_s;
  logic       good;
  logic       tmo_hit;
  logic [7:0] meas;
  logic [3:0] gc_inc;

`ifdef DIVMON_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], mon.div_in};
    sample = sync_q[1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= sync_d;
  end
`else
  always_comb sample = mon.div_in;
`endif

  always_comb begin
    edge_s  = sample ^ prev_q;
    meas    = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;
    good    = ({2'b0, meas} >= LO_V) && ({2'b0, meas} <= HI_V);
    tmo_hit = {2'b0, cnt_q} >= TMO_V;
    gc_inc  = ((state_q == LOST) ? 4'd0 : good_cnt_q) + 4'd1;

    prev_d     = sample;
    cnt_d      = edge_s ? 8'd0 : meas;
    state_d    = state_q;
    good_cnt_d = good_cnt_q;
    half_d     = half_q;
    rise_d     = edge_s & sample;
    fall_d     = edge_s & ~sample;
    pv_d       = 1'b0;
    err_d      = 1'b0;

    // An edge always takes priority over a coincident timeout.
    if (edge_s) begin
      if (state_q == IDLE) begin
        state_d    = ACQUIRE;
        good_cnt_d = 4'd0;
      end else begin
        pv_d   = 1'b1;
        half_d = meas;
        if (state_q == LOCKED) begin
          if (!good) begin
            state_d = LOST;
            err_d   = 1'b1;
          end
        end else if (good) begin
          good_cnt_d = gc_inc;
          state_d    = (gc_inc >= LOCK_V) ? LOCKED : ACQUIRE;
        end else begin
          good_cnt_d = 4'd0;
          state_d    = ACQUIRE;
          err_d      = 1'b1;
        end
      end
    end else if (tmo_hit) begin
      unique case (state_q)
        ACQUIRE: state_d = IDLE;
        LOCKED:  state_d = LOST;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      prev_q     <= 1'b0;
      cnt_q      <= 8'd0;
      good_cnt_q <= 4'd0;
      half_q     <= 8'd0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      pv_q       <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      cnt_q      <= cnt_d;
      good_cnt_q <= good_cnt_d;
      half_q     <= half_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      pv_q       <= pv_d;
      err_q      <= err_d;
    end
  end

  assign mon.rise_pulse   = rise_q;
  assign mon.fall_pulse   = fall_q;
  assign mon.half_period  = half_q;
  assign mon.period_valid = pv_q;
  assign mon.locked       = (state_q == LOCKED);
  assign mon.err_pulse    = err_q;
  assign mon.timeout      = tmo_hit;
endmodule

// File: tb/tb_divclk_monitor.sv
// tb_divclk_monitor: random half-period stimulus against an event-level
// reference model of the monitor; every output is compared each cycle.
module tb_divclk_monitor;
  localparam int EXP_HALF = 8;
  localparam int TOL      = 1;
  localparam int LOCK_CNT = 4;
  localparam int TMO      = 2 * EXP_HALF + TOL;
`ifdef DIVMON_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  localparam int S_IDLE = 0;
  localparam int S_ACQ  = 1;
  localparam int S_LOCK = 2;
  localparam int S_LOST = 3;

  logic clk;
  logic rst_n;
  logic dv;

  divclk_monitor_if mon_if();

  divclk_monitor #(
    .EXP_HALF(EXP_HALF),
    .TOL(TOL),
    .LOCK_CNT(LOCK_CNT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mon(mon_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_chk;
  int n_fail;

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model state: time of last seen transition, lock progress.
  int   t;
  int   last;
  int   st;
  int   gc;
  logic dl[0:3];
  int   m_half;
  bit   m_rise, m_fall, m_pv, m_err, m_tmo;

  function automatic int sat255(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic model_step();
    logic w, wp;
    bit   e, good;
    int   meas;
    t++;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dl[i] = 1'b0;
      st = S_IDLE; gc = 0; last = t; m_half = 0;
      m_rise = 0; m_fall = 0; m_pv = 0; m_err = 0; m_tmo = 0;
      return;
    end
    for (int i = 3; i > 0; i--) dl[i] = dl[i-1];
    dl[0] = dv;
    w  = dl[LAT-1];
    wp = dl[LAT];
    e  = (w != wp);
    m_rise = e && w;
    m_fall = e && !w;
    m_pv = 0;
    m_err = 0;
    if (e) begin
      meas = sat255(t - last);
      good = (meas >= EXP_HALF - TOL) && (meas <= EXP_HALF + TOL);
      if (st == S_IDLE) begin
        st = S_ACQ;
        gc = 0;
      end else begin
        m_pv = 1;
        m_half = meas;
        if (!good) begin
          m_err = 1;
          gc = 0;
          st = (st == S_LOCK) ? S_LOST : S_ACQ;
        end else if (st != S_LOCK) begin
          gc = ((st == S_LOST) ? 0 : gc) + 1;
          st = (gc >= LOCK_CNT) ? S_LOCK : S_ACQ;
        end
      end
      last = t;
    end else if (sat255(t - 1 - last) >= TMO) begin
      if (st == S_ACQ)  st = S_IDLE;
      if (st == S_LOCK) st = S_LOST;
    end
    m_tmo = !e && (sat255(t - last) >= TMO);
  endtask

  task automatic cycle(input logic rs);
    mon_if.div_in = dv;
    rst_n = rs;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("rise",   int'(mon_if.rise_pulse),   int'(m_rise));
    check("fall",   int'(mon_if.fall_pulse),   int'(m_fall));
    check("half",   int'(mon_if.half_period),  m_half);
    check("pvalid", int'(mon_if.period_valid), int'(m_pv));
    check("locked", int'(mon_if.locked),       int'(st == S_LOCK));
    check("err",    int'(mon_if.err_pulse),    int'(m_err));
    check("tmo",    int'(mon_if.timeout),      int'(m_tmo));
  endtask

  task automatic half(input int n);
    dv = ~dv;
    repeat (n) cycle(1'b1);
  endtask

  task automatic hold(input int n);
    repeat (n) cycle(1'b1);
  endtask

  initial begin
    n_chk = 0; n_fail = 0; t = 0; last = 0;
    st = S_IDLE; gc = 0; m_half = 0;
    for (int i = 0; i < 4; i++) dl[i] = 1'b0;
    dv = 1'b0;
    rst_n = 1'b0;
    mon_if.div_in = 1'b0;

    repeat (3) cycle(1'b0);
    hold(5);
    repeat (10) half(8);
    check("lock_nominal", int'(mon_if.locked), 1);

    half(11);
    repeat (6) half(8);
    check("relock_after_11", int'(mon_if.locked), 1);

    repeat (30) half(6 + int'($urandom % 5));
    repeat (6) half(8);

    hold(40);
    check("hold_timeout", int'(mon_if.timeout), 1);
    check("hold_unlocked", int'(mon_if.locked), 0);
    repeat (6) half(8);

    // Single-cycle reset in the middle of a locked half-period.
    dv = ~dv;
    hold(3);
    cycle(1'b0);
    check("rst_locked", int'(mon_if.locked), 0);
    check("rst_half", int'(mon_if.half_period), 0);
    hold(5);
    repeat (8) half(8);

    hold(300);
    half(8);
    check("sat_meas", int'(mon_if.half_period), 255);

    repeat (60) half(2 + int'($urandom % 29));
    repeat (8) half(8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
